// File: rtl/i2c_bus_cond_detect.sv
// I2C bus-condition detector: synchronizes and glitch-filters SDA/SCL, then
// reports SCL edges, START / repeated START / STOP, bus-busy and SCL-low timeout.

module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic line_i,
   output logic filt_o,
   output logic prev_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '1;
         cnt_q  <= '0;
         filt_o <= 1'b1;
         prev_o <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
         prev_o <= filt_o;
         // filtered level only follows after FILTER_LEN consecutive disagreeing samples
         if (synced == filt_o) begin
            cnt_q <= '0;
         end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
            filt_o <= synced;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end
endmodule

module i2c_bus_cond_detect #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TIMEOUT_W   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic                 sda_i,
   input  logic                 scl_i,
   input  logic [TIMEOUT_W-1:0] timeout_limit_i,
   output logic                 sda_f_o,
   output logic                 scl_f_o,
   output logic                 scl_rise_o,
   output logic                 scl_fall_o,
   output logic                 start_o,
   output logic                 rstart_o,
   output logic                 stop_o,
   output logic                 bus_busy_o,
   output logic                 timeout_o
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic                 sda_prev, scl_prev;
   logic [0:0]           state_q;
   logic [TIMEOUT_W-1:0] tcnt_q, tcnt_inc;
   logic                 sda_fall_c, sda_rise_c, to_hit;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(sda_i), .filt_o(sda_f_o), .prev_o(sda_prev)
   );
   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(scl_i), .filt_o(scl_f_o), .prev_o(scl_prev)
   );

   // SCL must be stable high across the SDA edge; a simultaneous SCL change masks it
   assign sda_fall_c = sda_prev & ~sda_f_o & scl_prev & scl_f_o;
   assign sda_rise_c = ~sda_prev & sda_f_o & scl_prev & scl_f_o;

   assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
   assign to_hit   = (state_q == ST_BUSY) && !scl_f_o && (timeout_limit_i != '0) &&
                     (tcnt_inc >= timeout_limit_i);

   assign bus_busy_o = (state_q == ST_BUSY);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         tcnt_q     <= '0;
         scl_rise_o <= 1'b0;
         scl_fall_o <= 1'b0;
         start_o    <= 1'b0;
         rstart_o   <= 1'b0;
         stop_o     <= 1'b0;
         timeout_o  <= 1'b0;
      end else if (!en_i) begin
         state_q    <= ST_IDLE;
         tcnt_q     <= '0;
         scl_rise_o <= 1'b0;
         scl_fall_o <= 1'b0;
         start_o    <= 1'b0;
         rstart_o   <= 1'b0;
         stop_o     <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         scl_rise_o <= ~scl_prev & scl_f_o;
         scl_fall_o <= scl_prev & ~scl_f_o;
         start_o    <= (state_q == ST_IDLE) && sda_fall_c;
         rstart_o   <= (state_q == ST_BUSY) && sda_fall_c;
         stop_o     <= sda_rise_c;
         timeout_o  <= to_hit;

         if (sda_rise_c)      state_q <= ST_IDLE;
         else if (sda_fall_c) state_q <= ST_BUSY;
         else if (to_hit)     state_q <= ST_IDLE;

         if ((state_q == ST_BUSY) && !scl_f_o && !to_hit) tcnt_q <= tcnt_inc;
         else                                             tcnt_q <= '0;
      end
   end
endmodule

// File: doc/i2c_bus_cond_detect.md
Name: i2c_bus_cond_detect

Overview:
Parametrised I2C bus-condition detector with a configurable synchronizer depth and a per-line glitch filter. It reports SCL rising and falling edges, START, repeated START and STOP conditions. It also tracks bus-busy state and flags an SCL-low timeout. It sits between the I2C pad inputs and the slave/PWM register-access FSM, and replaces fixed 2-flop start/stop detection.

Parameters:
SYNC_STAGES, 2, synchronizer flops per line; legal range 2..4.
FILTER_LEN, 3, consecutive cycles a synced line must differ from its filtered value before the filtered value follows; legal range 1..15.
TIMEOUT_W, 16, width of the SCL-low timeout counter and limit.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; asynchronous, active-low
en_i  in  1  detector enable
sda_i  in  1  raw SDA pad input
scl_i  in  1  raw SCL pad input
timeout_limit_i  in  TIMEOUT_W  SCL-low timeout in clk cycles; 0 disables the timeout
sda_f_o  out  1  filtered SDA level
scl_f_o  out  1  filtered SCL level
scl_rise_o  out  1  one-cycle pulse on filtered SCL 0->1
scl_fall_o  out  1  one-cycle pulse on filtered SCL 1->0
start_o  out  1  one-cycle pulse: START detected from IDLE
rstart_o  out  1  one-cycle pulse: repeated START detected while BUSY
stop_o  out  1  one-cycle pulse: STOP detected
bus_busy_o  out  1  high between START and STOP or timeout
timeout_o  out  1  one-cycle pulse: SCL held low for timeout_limit_i cycles while BUSY

Behaviour:
- Reset (async assert, sync release): sync chains, filtered levels and prev registers = 1; filter counters = 0; FSM = IDLE; timeout counter = 0.
- Reset values of outputs: sda_f_o = scl_f_o = 1; all pulse outputs = 0; bus_busy_o = 0.
- Sync: each line is shifted through SYNC_STAGES flops; "synced" means the last stage.
- Filter, per line, with a 4-bit counter cnt:
  - synced == filtered: cnt <= 0.
  - synced != filtered and cnt == FILTER_LEN-1: filtered <= synced, cnt <= 0.
  - otherwise: cnt++.
  - Any glitch shorter than FILTER_LEN synced cycles is rejected.
- Prev registers hold the previous filtered values. All pulse outputs are registered, computed from (prev, filtered).
- Latency: a pad change stable before edge 1 updates the filtered level at edge SYNC_STAGES+FILTER_LEN. The resulting pulse is high after edge SYNC_STAGES+FILTER_LEN+1, for exactly one cycle. Default: filtered at edge 5, pulse after edge 6.
- Conditions:
  - SDA falling condition: sda prev = 1, sda filtered = 0, and scl prev = scl filtered = 1.
  - SDA rising condition: same, with SDA 0->1.
  - If SDA and filtered SCL change in the same cycle, no START/STOP is reported. The SCL edge pulse is still reported.
- FSM states IDLE and BUSY:
  - IDLE + SDA falling condition: start_o, go to BUSY.
  - BUSY + SDA falling condition: rstart_o, stay in BUSY; timeout counter cleared.
  - Any state + SDA rising condition: stop_o, go to IDLE (a STOP seen in IDLE still pulses).
  - BUSY + timeout: timeout_o, go to IDLE.
- bus_busy_o is registered and equals (state == BUSY).
- Timeout counter:
  - Counts while BUSY and scl filtered = 0, saturating at 2^TIMEOUT_W-1.
  - Cleared on scl filtered = 1 and in IDLE.
  - When it reaches timeout_limit_i and timeout_limit_i != 0: timeout_o pulses once and the FSM goes to IDLE.
  - timeout_limit_i is sampled every cycle; lowering it below the current count does not fire until the next count-up.
- en_i = 0:
  - Sync chain and filter keep running; sda_f_o/scl_f_o stay live.
  - FSM forced to IDLE, timeout counter cleared, all pulses suppressed.
  - Re-enabling does not produce spurious edges from stale prev values, because prev keeps tracking while disabled.
- Reset asserted mid-transaction: returns immediately to the reset values above; no pulse on release.

Test Plan:
- Defaults. SCL=1; drop SDA 1->0 and hold 20 clks -> start_o high for exactly one cycle, after edge 6 from the SDA change; bus_busy_o=1 from the next cycle.
- In BUSY: SDA 1->0 while SCL=1 -> rstart_o pulses once, start_o stays 0. Then SDA 0->1 with SCL=1 -> stop_o pulses once, bus_busy_o=0.
- Glitch rejection. 2-cycle SDA low glitch with SCL=1 and FILTER_LEN=3 -> no pulse, sda_f_o stays 1. A 3-cycle glitch -> start_o fires.
- SCL toggles with period 10 clks -> scl_fall_o and scl_rise_o each pulse once per transition. An SDA change while SCL=0 gives no START/STOP.
- timeout_limit_i=50. After START, hold SCL low 60 clks -> timeout_o pulses when the count reaches 50, bus_busy_o=0. timeout_limit_i=0 -> no timeout after 1000 clks.
- en_i=0 during a START sequence -> no pulses, bus_busy_o=0. Async reset mid-BUSY -> all outputs at reset values within the same cycle.
